// File: rtl/text_overlay.sv
// Character-cell text window drawn over a VGA pixel stream, with a clear FSM
// that fills the buffer with spaces. Define TEXT_OVERLAY_BLINK_EN for char[7] blink.
module text_overlay #(
  parameter int          COLS = 40,
  parameter int          ROWS = 4,
  parameter int          X0   = 80,
  parameter int          Y0   = 80,
  parameter logic [11:0] FG   = 12'hFFF,
  parameter logic [11:0] BG   = 12'h000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [9:0]              x,
  input  logic [9:0]              y,
  input  logic                    video_on,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [$clog2(COLS)-1:0] wr_col,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [7:0]              wr_char,
  output logic                    wr_err,
  input  logic                    clear_req,
  output logic                    busy,
  output logic [10:0]             rom_addr,
  input  logic [7:0]              rom_data,
  output logic                    hsync,
  output logic                    vsync,
  output logic [11:0]             rgb
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int N  = COLS * ROWS;
  localparam int AW = $clog2(N);
  localparam logic [9:0] XL = 10'(X0);
  localparam logic [9:0] XH = 10'(X0 + 8 * COLS);
  localparam logic [9:0] YL = 10'(Y0);
  localparam logic [9:0] YH = 10'(Y0 + 16 * ROWS);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          wr_ready_q, wr_err_q;
  logic          wr_fire, wr_in_range;
  logic [AW-1:0] wr_lin;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem [N];

  assign busy        = (state_q == CLEAR);
  assign wr_ready    = wr_ready_q;
  assign wr_err      = wr_err_q;
  assign wr_fire     = wr_valid & wr_ready_q;
  assign wr_in_range = ({1'b0, wr_col} < (CW+1)'(COLS)) && ({1'b0, wr_row} < (RW+1)'(ROWS));
  assign wr_lin      = AW'(wr_row) * AW'(COLS) + AW'(wr_col);

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      default: begin
        if (clr_addr_q == AW'(N - 1)) begin
          state_d    = IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
    endcase
  end

  // wr_ready is closed whenever busy, so the clear owns the write port alone
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_lin;
    mem_wdata = wr_char;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr_q;
      mem_wdata = 8'h20;
    end else if (wr_fire && wr_in_range) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      wr_ready_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      wr_ready_q <= (state_d != CLEAR);
      wr_err_q   <= wr_fire & ~wr_in_range;
    end
  end

  // Pixel pipeline: S1 address decode, S2 buffer read, S3 glyph bit select
  logic [9:0]    dx, dy;
  logic          in_win;
  logic [AW-1:0] pix_lin;
  logic [AW-1:0] s1_idx_q;
  logic [3:0]    s1_grow_q, s2_grow_q;
  logic [2:0]    s1_bc_q, s2_bc_q, s3_bc_q;
  logic          s1_win_q, s2_win_q, s3_win_q;
  logic          s1_von_q, s2_von_q, s3_von_q;
  logic          s1_hs_q, s2_hs_q, s3_hs_q;
  logic          s1_vs_q, s2_vs_q, s3_vs_q;
  logic          s3_attr_q;
  logic [7:0]    char_q;
  logic          glyph_bit, blink_phase;

  assign dx      = x - XL;
  assign dy      = y - YL;
  assign in_win  = (x >= XL) && (x < XH) && (y >= YL) && (y < YH);
  assign pix_lin = AW'(dy[9:4]) * AW'(COLS) + AW'(dx[9:3]);

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    char_q <= mem[s1_idx_q];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_idx_q  <= '0;
      s1_grow_q <= '0;
      s2_grow_q <= '0;
      s1_bc_q   <= '0;
      s2_bc_q   <= '0;
      s3_bc_q   <= '0;
      {s1_win_q, s2_win_q, s3_win_q} <= '0;
      {s1_von_q, s2_von_q, s3_von_q} <= '0;
      {s1_hs_q, s2_hs_q, s3_hs_q}    <= '1;
      {s1_vs_q, s2_vs_q, s3_vs_q}    <= '1;
      s3_attr_q <= 1'b0;
    end else begin
      s1_idx_q  <= in_win ? pix_lin : '0;
      s1_grow_q <= dy[3:0];
      s1_bc_q   <= dx[2:0];
      s1_win_q  <= in_win;
      s1_von_q  <= video_on;
      s1_hs_q   <= hsync_in;
      s1_vs_q   <= vsync_in;
      s2_grow_q <= s1_grow_q;
      s2_bc_q   <= s1_bc_q;
      s2_win_q  <= s1_win_q;
      s2_von_q  <= s1_von_q;
      s2_hs_q   <= s1_hs_q;
      s2_vs_q   <= s1_vs_q;
      s3_bc_q   <= s2_bc_q;
      s3_win_q  <= s2_win_q;
      s3_von_q  <= s2_von_q;
      s3_hs_q   <= s2_hs_q;
      s3_vs_q   <= s2_vs_q;
      s3_attr_q <= char_q[7];
    end
  end

  assign rom_addr  = {char_q[6:0], s2_grow_q};
  assign glyph_bit = rom_data[3'd7 - s3_bc_q];
  assign hsync     = s3_hs_q;
  assign vsync     = s3_vs_q;

`ifdef TEXT_OVERLAY_BLINK_EN
  logic       vs_prev_q;
  logic [4:0] blink_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_prev_q   <= 1'b1;
      blink_cnt_q <= '0;
    end else begin
      vs_prev_q <= vsync_in;
      if (vs_prev_q && !vsync_in) blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  assign blink_phase = blink_cnt_q[4];
`else
  assign blink_phase = 1'b0;
`endif

  always_comb begin
    if (!s3_von_q)                                          rgb = 12'h000;
    else if (s3_win_q && glyph_bit && !(s3_attr_q && blink_phase)) rgb = FG;
    else                                                    rgb = BG;
  end
endmodule

// File: tb/tb_text_overlay.sv
// Scoreboarded bench for text_overlay: pixel expectations are queued at drive
// time and popped three cycles later; control outputs are checked inline.
module tb_text_overlay;
  localparam int COLS = 40;
  localparam int ROWS = 4;
  localparam int N    = COLS * ROWS;
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [9:0]  x = '0, y = '0;
  logic        video_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic        wr_valid = 1'b0, wr_ready;
  logic [5:0]  wr_col = '0;
  logic [1:0]  wr_row = '0;
  logic [7:0]  wr_char = '0;
  logic        wr_err, clear_req = 1'b0, busy;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic        hsync, vsync;
  logic [11:0] rgb;

  text_overlay #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_col(wr_col), .wr_row(wr_row), .wr_char(wr_char),
    .wr_err(wr_err), .clear_req(clear_req), .busy(busy), .rom_addr(rom_addr),
    .rom_data(rom_data), .hsync(hsync), .vsync(vsync), .rgb(rgb)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input logic [10:0] a);
    return a[7:0] ^ {a[3:0], a[10:7]};
  endfunction

  always @(posedge clk) rom_data <= rom_f(rom_addr);

  typedef struct {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic        chk;
    int          px;
    int          py;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] mem_m [N];
  int         cnt_m = 0;
  int         passed = 0, failed = 0, total = 0;
  logic       sb_on = 1'b0, pchk = 1'b0, rsync = 1'b1;
  logic [9:0] px = '0, py = '0;
  logic       pvon = 1'b0, phs = 1'b1, pvs = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_rgb(input int xx, input int yy, input logic von);
    logic [7:0] ch, d;
    int c, r, g, b;
    if (!von) return 12'h000;
    if (xx < 80 || xx >= 80 + 8 * COLS || yy < 80 || yy >= 80 + 16 * ROWS) return BG;
    c  = (xx - 80) / 8;
    r  = (yy - 80) / 16;
    g  = (yy - 80) % 16;
    b  = (xx - 80) % 8;
    ch = mem_m[r * COLS + c];
    d  = rom_f({ch[6:0], 4'(g)});
`ifdef TEXT_OVERLAY_BLINK_EN
    if (ch[7] && ((cnt_m / 16) % 2 == 1)) return BG;
`endif
    return d[7 - b] ? FG : BG;
  endfunction

  // One pixel clock: compare the entry due now, then drive and queue the next.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (sb_on && sbq.size() == 3) begin
      e = sbq.pop_front();
      chk("hsync", 32'(hsync), 32'(e.hs));
      chk("vsync", 32'(vsync), 32'(e.vs));
      if (e.chk) chk($sformatf("rgb x=%0d y=%0d", e.px, e.py), 32'(rgb), 32'(e.rgb));
    end
    if (rsync) begin
      phs = 1'($urandom_range(0, 1));
      pvs = 1'($urandom_range(0, 1));
    end
    x = px; y = py; video_on = pvon; hsync_in = phs; vsync_in = pvs;
    if (sb_on)
      sbq.push_back('{hs: phs, vs: pvs, rgb: exp_rgb(int'(px), int'(py), pvon),
                      chk: pchk, px: int'(px), py: int'(py)});
  endtask

  task automatic scan(input int xa, input int xb, input int ya, input int yb, input logic von);
    pchk = 1'b1;
    for (int yy = ya; yy <= yb; yy++)
      for (int xx = xa; xx <= xb; xx++) begin
        px = 10'(xx); py = 10'(yy); pvon = von;
        step();
      end
    pchk = 1'b0; pvon = 1'b0;
    repeat (3) step();
    $display("scan x=%0d..%0d y=%0d..%0d video_on=%0d", xa, xb, ya, yb, von);
  endtask

  task automatic wr(input int c, input int r, input logic [7:0] ch, input logic exp_err);
    wr_valid = 1'b1; wr_col = 6'(c); wr_row = 2'(r); wr_char = ch;
    chk("wr_ready before write", 32'(wr_ready), 32'd1);
    step();
    wr_valid = 1'b0;
    chk("wr_err pulse", 32'(wr_err), 32'(exp_err));
    step();
    chk("wr_err after pulse", 32'(wr_err), 32'd0);
    if (c < COLS && r < ROWS) mem_m[r * COLS + c] = ch;
    $display("write col=%0d row=%0d char=%02h err_expected=%0d", c, r, ch, exp_err);
  endtask

  task automatic wait_clear(input string tag, input logic mid_req);
    int n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      clear_req = mid_req && (n == 20);
      step();
    end
    clear_req = 1'b0;
    chk({tag, " busy cycles"}, 32'(n), 32'd160);
    chk({tag, " busy low"}, 32'(busy), 32'd0);
    chk({tag, " wr_ready high"}, 32'(wr_ready), 32'd1);
    for (int i = 0; i < N; i++) mem_m[i] = 8'h20;
    $display("clear %s finished after %0d busy cycles", tag, n);
  endtask

  task automatic scan_all_rows();
    for (int r = 0; r < ROWS; r++)
      scan(78, 80 + 8 * COLS + 1, 80 + 16 * r + (r * 5) % 16, 80 + 16 * r + (r * 5) % 16, 1'b1);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1;
    chk("reset rgb", 32'(rgb), 32'd0);
    chk("reset hsync", 32'(hsync), 32'd1);
    chk("reset vsync", 32'(vsync), 32'd1);
    chk("reset wr_err", 32'(wr_err), 32'd0);
    chk("reset busy", 32'(busy), 32'd1);
    chk("reset wr_ready", 32'(wr_ready), 32'd0);
    repeat (3) step();
    reset_n = 1'b1;
    sb_on = 1'b1;
    wait_clear("reset", 1'b0);
    scan_all_rows();

    wr(0, 0, 8'h41, 1'b0);
    scan(79, 88, 80, 95, 1'b1);

    wr(40, 0, 8'h5A, 1'b1);
    wr(39, 3, 8'h7E, 1'b0);
    scan_all_rows();

    scan(80, 100, 80, 84, 1'b0);

    wr_valid = 1'b1; wr_col = 6'd5; wr_row = 2'd2; wr_char = 8'h42; clear_req = 1'b1;
    chk("wr_ready with clear", 32'(wr_ready), 32'd1);
    step();
    wr_valid = 1'b0; clear_req = 1'b0;
    chk("wr_err on clear write", 32'(wr_err), 32'd0);
    chk("wr_ready during clear", 32'(wr_ready), 32'd0);
    $display("write col=5 row=2 char=42 with clear_req");
    wait_clear("write+clear", 1'b1);
    scan(80, 127, 80 + 32, 80 + 47, 1'b1);
    scan(80, 87, 80, 95, 1'b1);

    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (40) step();
    sb_on = 1'b0;
    sbq.delete();
    reset_n = 1'b0;
    #1;
    chk("mid-clear reset busy", 32'(busy), 32'd1);
    chk("mid-clear reset rgb", 32'(rgb), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    sb_on = 1'b1;
    rsync = 1'b0; phs = 1'b1; pvs = 1'b1;
    wait_clear("mid-clear reset", 1'b0);
    cnt_m = 0;

    wr(1, 1, 8'hC1, 1'b0);
    for (int f = 0; f < 32; f++) begin
      scan(88, 95, 96, 111, 1'b1);
      pvs = 1'b0; step(); step();
      pvs = 1'b1; step(); step();
      cnt_m++;
      $display("frame %0d done", f);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
